// File: rtl/common.sv
// Shared formula/clause/literal types and sizing constants for the SAT datapath.
package common;

    localparam int unsigned NUMBER_CLAUSES = 4;
    localparam int unsigned NUMBER_LITS    = 3;
    localparam int unsigned VAR_WIDTH      = 4;

    localparam int unsigned CLS_CNT_W = $clog2(NUMBER_CLAUSES + 1);
    localparam int unsigned LIT_CNT_W = $clog2(NUMBER_LITS + 1);
    localparam int unsigned CLS_IDX_W = (NUMBER_CLAUSES > 1) ? $clog2(NUMBER_CLAUSES) : 1;
    localparam int unsigned LIT_IDX_W = (NUMBER_LITS > 1) ? $clog2(NUMBER_LITS) : 1;

    typedef struct packed {
        logic [VAR_WIDTH-1:0] var_id;
        logic                 neg;
    } lit_t;

    typedef struct packed {
        lit_t [NUMBER_LITS-1:0] lits;
        logic [LIT_CNT_W-1:0]   len;
    } clause_t;

    typedef struct packed {
        clause_t [NUMBER_CLAUSES-1:0] clauses;
        logic [CLS_CNT_W-1:0]         len;
    } formula_t;

    localparam lit_t     ZERO_LIT     = '0;
    localparam clause_t  ZERO_CLAUSE  = '0;
    localparam formula_t ZERO_FORMULA = '0;

    function automatic lit_t complement(lit_t l);
        return lit_t'{var_id: l.var_id, neg: ~l.neg};
    endfunction

endpackage

// File: rtl/clause_simplify.sv
// Combinational simplification of one clause under the assignment lit=true.
module clause_simplify
    import common::*;
(
    input  clause_t clause,
    input  lit_t    lit,
    output logic    satisfied,
    output clause_t out_clause
);

    lit_t                 neg_lit;
    logic                 lit_valid;
    logic [LIT_CNT_W-1:0] count;

    always_comb begin
        neg_lit    = complement(lit);
        // Variable 0 is reserved, so a zero literal can never match anything.
        lit_valid  = (lit.var_id != '0);
        satisfied  = 1'b0;
        out_clause = ZERO_CLAUSE;
        count      = '0;
        for (int i = 0; i < NUMBER_LITS; i++) begin
            if (lit_valid && (LIT_CNT_W'(i) < clause.len) && (clause.lits[i] == lit)) begin
                satisfied = 1'b1;
            end
        end
        for (int i = 0; i < NUMBER_LITS; i++) begin
            if ((LIT_CNT_W'(i) < clause.len) && !(lit_valid && (clause.lits[i] == neg_lit))) begin
                out_clause.lits[count[LIT_IDX_W-1:0]] = clause.lits[i];
                count = count + LIT_CNT_W'(1);
            end
        end
        out_clause.len = count;
    end

endmodule

// File: rtl/simplify_formula.sv
// Applies one unit literal to a latched formula, one clause per cycle, compacting the
// surviving clauses into out_formula and flagging conflict / all-satisfied.
module simplify_formula
    import common::*;
(
    input  logic     clock,
    input  logic     reset,
    input  logic     start,
    input  formula_t in_formula,
    input  lit_t     in_lit,
    output logic     busy,
    output logic     ended,
    output logic     conflict,
    output logic     all_sat,
    output formula_t out_formula
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e               state;
    formula_t             formula_q;
    lit_t                 lit_q;
    logic [CLS_CNT_W-1:0] rd;
    logic [CLS_CNT_W-1:0] wr;

    logic [CLS_CNT_W-1:0] limit;
    logic [CLS_CNT_W-1:0] next_len;
    logic                 last;
    clause_t              cur_clause;
    clause_t              simp_clause;
    logic                 cur_sat;

    always_comb begin
        limit = (formula_q.len > CLS_CNT_W'(NUMBER_CLAUSES)) ? CLS_CNT_W'(NUMBER_CLAUSES)
                                                             : formula_q.len;
        cur_clause = formula_q.clauses[rd[CLS_IDX_W-1:0]];
        last       = ((rd + CLS_CNT_W'(1)) == limit);
        next_len   = cur_sat ? wr : wr + CLS_CNT_W'(1);
    end

    clause_simplify u_clause_simplify (
        .clause     (cur_clause),
        .lit        (lit_q),
        .satisfied  (cur_sat),
        .out_clause (simp_clause)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= StIdle;
            formula_q   <= ZERO_FORMULA;
            lit_q       <= ZERO_LIT;
            rd          <= '0;
            wr          <= '0;
            busy        <= 1'b0;
            ended       <= 1'b0;
            conflict    <= 1'b0;
            all_sat     <= 1'b0;
            out_formula <= ZERO_FORMULA;
        end else begin
            unique case (state)
                StIdle: begin
                    ended <= 1'b0;
                    if (start) begin
                        formula_q   <= in_formula;
                        lit_q       <= in_lit;
                        out_formula <= ZERO_FORMULA;
                        conflict    <= 1'b0;
                        all_sat     <= 1'b0;
                        rd          <= '0;
                        wr          <= '0;
                        busy        <= 1'b1;
                        state       <= StScan;
                    end
                end
                StScan: begin
                    if (limit == '0) begin
                        all_sat <= 1'b1;
                        ended   <= 1'b1;
                        state   <= StDone;
                    end else begin
                        rd <= rd + CLS_CNT_W'(1);
                        if (!cur_sat) begin
                            out_formula.clauses[wr[CLS_IDX_W-1:0]] <= simp_clause;
                        end
                        // An emptied clause is a conflict: it is stored but not counted.
                        if (!cur_sat && (simp_clause.len == '0)) begin
                            conflict <= 1'b1;
                            ended    <= 1'b1;
                            state    <= StDone;
                        end else begin
                            wr              <= next_len;
                            out_formula.len <= next_len;
                            if (last) begin
                                all_sat <= (next_len == '0);
                                ended   <= 1'b1;
                                state   <= StDone;
                            end
                        end
                    end
                end
                StDone: begin
                    ended <= 1'b0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/simplify_formula.md
SIMPLIFY_FORMULA -- requirements
Module: simplify_formula

Interface
REQ-001 SHALL have port clock, input, 1, the only clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high.
REQ-003 SHALL have port start, input, 1, request to simplify; sampled only in IDLE.
REQ-004 SHALL have port in_formula, input, formula, formula to simplify; sampled with start.
REQ-005 SHALL have port in_lit, input, lit, literal to assign true (output of unit-clause search); sampled with start.
REQ-006 SHALL have port busy, output, 1, high in every non-IDLE state.
REQ-007 SHALL have port ended, output, 1, single-cycle pulse marking that the result is valid.
REQ-008 SHALL have port conflict, output, 1, an empty clause was produced; valid with ended, held until next accepted start.
REQ-009 SHALL have port all_sat, output, 1, the result has zero clauses and no conflict; valid with ended, held until next accepted start.
REQ-010 SHALL have port out_formula, output, formula, simplified formula; held stable from ended until next accepted start.

Function
REQ-011 SHALL implement FSM IDLE -> SCAN -> DONE -> IDLE.
REQ-012 IDLE: on start=1, SHALL latch in_formula and in_lit, clear out_formula to ZERO_FORMULA, clear conflict/all_sat, set rd=0 and wr=0, and go to SCAN.
REQ-013 SCAN SHALL process exactly one clause per cycle: clause rd of the latched formula.
REQ-014 A clause SHALL count as satisfied if any literal at position < len equals in_lit (same var, same sign); a satisfied clause SHALL be dropped, and wr SHALL not advance.
REQ-015 If the clause is not satisfied, every literal at position < len equal to the complement of in_lit SHALL be removed. Remaining literals SHALL be compacted in original order, with unused slots set to ZERO_LIT. The clause SHALL be written to out_formula.clauses[wr], and wr and out_formula.len SHALL increment.
REQ-016 A clause containing both in_lit and its complement SHALL be treated as satisfied.
REQ-017 If a written clause has len 0, conflict SHALL be set and the FSM SHALL go to DONE on the same edge; later clauses SHALL not be processed.
REQ-018 With L = min(in_formula.len, NUMBER_CLAUSES), SCAN SHALL go to DONE after clause L-1 is processed. When L=0, it SHALL go to DONE on the first SCAN cycle.
REQ-019 ended SHALL be high exactly during the DONE cycle. With start accepted at edge N and no conflict, ended SHALL be high in the cycle after edge N+max(L,1).
REQ-020 all_sat SHALL be set on entry to DONE iff out_formula.len==0 and conflict==0.
REQ-021 A start while busy SHALL be ignored. The latched inputs SHALL not change during SCAN.
REQ-022 Variable 0 is reserved. in_lit==ZERO_LIT SHALL copy all L clauses unchanged (no match possible).
REQ-023 Widths: rd and wr SHALL be sized to count 0..NUMBER_CLAUSES; the per-clause len SHALL be sized to count 0..NUMBER_LITS; no wrap-around is permitted.

Reset
REQ-024 reset=1 at a rising edge SHALL force IDLE and set busy, ended, conflict and all_sat to 0 and out_formula to ZERO_FORMULA, regardless of state.
REQ-025 Reset mid-SCAN SHALL abort with no ended pulse. reset SHALL take priority over start on the same edge.

Structure
REQ-026 The shared package common SHALL hold NUMBER_CLAUSES, NUMBER_LITS, VAR_WIDTH, lit {var_id, neg}, clause {lits[NUMBER_LITS], len}, formula {clauses[NUMBER_CLAUSES], len}, ZERO_LIT, ZERO_CLAUSE and ZERO_FORMULA.
REQ-027 Per-clause logic SHALL be a combinational sub-module clause_simplify (clause, lit -> satisfied, out clause), instantiated once and indexed by rd.
REQ-028 The output interface SHALL match the consumption pattern of the unit-clause search, so that out_formula feeds it directly.

Verification
REQ-029 The bench SHALL cover: formula {(x1),(~x1,x2),(x3,x4)}, in_lit=x1 -> out {(x2),(x3,x4)}, conflict=0, all_sat=0, ended 3 cycles after start.
REQ-030 The bench SHALL cover: formula {(x1,x2),(x1)}, in_lit=x1 -> out len 0, all_sat=1, conflict=0.
REQ-031 The bench SHALL cover: formula {(x2,x3),(~x1),(x4)}, in_lit=x1 -> conflict=1, ended after clause 1, out len 1 holding (x2,x3) plus an empty clause 1.
REQ-032 The bench SHALL cover: formula len 0 -> ended 1 cycle after start, all_sat=1; a start pulsed during SCAN of a 4-clause run is ignored.
REQ-033 The bench SHALL cover: reset asserted in the 2nd SCAN cycle -> no ended pulse, busy=0, out_formula=ZERO_FORMULA next cycle; a new start then completes normally.
REQ-034 The bench SHALL cover: clause (~x1,x5,~x1) with in_lit=x1 -> (x5), len 1, slots 1..NUMBER_LITS-1 = ZERO_LIT.
